// File: rtl/mtr_pi_seq.sv
`default_nettype none
// mtr_pi_seq: meter event latch and priority-interrupt request sequencer.
// Rev 1.0 - initial release.

module mtr_pi_seq #(
  parameter int HOLD_CYC = 2
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_cono_mtr,
  input  logic [18:35] i_ebus_data,
  input  logic [0:3]   i_cnt_cry,
  input  logic         i_interval_done,
  input  logic         i_honor,
  output logic [1:7]   o_pi_req,
  output logic         o_vector_req,
  output logic [0:1]   o_incr_sel,
  output logic         o_func_valid,
  output logic [0:2]   o_pia,
  output logic [0:4]   o_pend
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_XFER = 2'd2;
  localparam logic [1:0] c_DROP = 2'd3;
  localparam logic [2:0] c_SEL_INT = 3'd4;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic [0:2] r_pia;
  logic [0:4] r_pend;
  logic       r_int_d;
  logic [2:0] r_sel;
  logic [2:0] r_hold;

  logic       w_int_rise;
  logic [0:4] w_set;
  logic [0:4] w_clr;
  logic [0:4] w_srv_mask;
  logic [2:0] w_pri;
  logic       w_xfer_last;
  logic       w_unused_ebus;

  assign w_unused_ebus = ^i_ebus_data[19:32];
  assign w_int_rise    = i_interval_done & ~r_int_d;
  assign w_set         = {i_cnt_cry, w_int_rise};
  assign w_xfer_last   = (r_state == c_XFER) && (r_hold == 3'(HOLD_CYC - 1));

  always_comb begin
    w_srv_mask = '0;
    for (int i = 0; i < 5; i++) begin
      w_srv_mask[i] = (r_sel == 3'(i));
    end
  end

  // New events are OR'ed in after clearing, so a same-edge set always wins.
  always_comb begin
    w_clr = '0;
    if (i_cono_mtr && i_ebus_data[18]) begin
      w_clr = '1;
    end
    if (w_xfer_last) begin
      w_clr = w_clr | w_srv_mask;
    end
  end

  always_comb begin
    w_pri = c_SEL_INT;
    if (r_pend[0])      w_pri = 3'd0;
    else if (r_pend[1]) w_pri = 3'd1;
    else if (r_pend[2]) w_pri = 3'd2;
    else if (r_pend[3]) w_pri = 3'd3;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: if ((|r_pend) && (r_pia != 3'd0)) w_next = c_REQ;
      c_REQ: begin
        if (i_cono_mtr || (r_pend == '0)) w_next = c_IDLE;
        else if (i_honor)                 w_next = c_XFER;
      end
      c_XFER: if (w_xfer_last) w_next = c_DROP;
      c_DROP: if (!i_honor)    w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    o_pi_req     = '0;
    o_func_valid = (r_state == c_XFER);
    o_vector_req = (r_state == c_XFER) && (r_sel == c_SEL_INT);
    o_incr_sel   = '0;
    if ((r_state == c_XFER) && (r_sel != c_SEL_INT)) begin
      o_incr_sel = r_sel[1:0];
    end
    for (int l = 1; l <= 7; l++) begin
      o_pi_req[l] = (r_state == c_REQ) && (r_pia == 3'(l));
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pia   <= '0;
      r_pend  <= '0;
      r_int_d <= 1'b0;
      r_sel   <= '0;
      r_hold  <= '0;
    end else begin
      r_int_d <= i_interval_done;
      r_pend  <= (r_pend & ~w_clr) | w_set;
      if (i_cono_mtr) begin
        r_pia <= i_ebus_data[33:35];
      end
      if ((r_state == c_REQ) && (w_next == c_XFER)) begin
        r_sel <= w_pri;
      end
      r_hold <= (r_state == c_XFER) ? r_hold + 3'd1 : 3'd0;
    end
  end

  assign o_pia  = r_pia;
  assign o_pend = r_pend;

endmodule

`default_nettype wire

// File: tb/tb_mtr_pi_seq.sv
`default_nettype none
// tb_mtr_pi_seq: directed self-checking bench for mtr_pi_seq.
// Rev 1.0 - initial release.

module tb_mtr_pi_seq;

  logic         clk;
  logic         i_rst_n;
  logic         i_cono_mtr;
  logic [18:35] i_ebus_data;
  logic [0:3]   i_cnt_cry;
  logic         i_interval_done;
  logic         i_honor;
  logic [1:7]   o_pi_req;
  logic         o_vector_req;
  logic [0:1]   o_incr_sel;
  logic         o_func_valid;
  logic [0:2]   o_pia;
  logic [0:4]   o_pend;

  int checks = 0;
  int errors = 0;

  mtr_pi_seq #(.HOLD_CYC(2)) u_dut (
    .clk             (clk),
    .i_rst_n         (i_rst_n),
    .i_cono_mtr      (i_cono_mtr),
    .i_ebus_data     (i_ebus_data),
    .i_cnt_cry       (i_cnt_cry),
    .i_interval_done (i_interval_done),
    .i_honor         (i_honor),
    .o_pi_req        (o_pi_req),
    .o_vector_req    (o_vector_req),
    .o_incr_sel      (o_incr_sel),
    .o_func_valid    (o_func_valid),
    .o_pia           (o_pia),
    .o_pend          (o_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cono(input logic clr, input int pia);
    i_cono_mtr      = 1'b1;
    i_ebus_data     = '0;
    i_ebus_data[18] = clr;
    i_ebus_data[33:35] = 3'(pia);
  endtask

  task automatic end_cono();
    i_cono_mtr  = 1'b0;
    i_ebus_data = '0;
  endtask

  // Entered with the FSM in REQ; leaves it one cycle after returning to IDLE.
  task automatic serve(input int lvl, input logic vec, input int sel);
    logic [1:7] e;
    e = '0;
    e[lvl] = 1'b1;
    check("req_level", 32'(o_pi_req), 32'(e));
    i_honor = 1'b1;
    tick();
    check("xfer_valid1", 32'(o_func_valid), 32'd1);
    check("xfer_vector", 32'(o_vector_req), 32'(vec));
    check("xfer_sel", 32'(o_incr_sel), 32'(sel));
    check("xfer_no_req", 32'(o_pi_req), 32'd0);
    tick();
    check("xfer_valid2", 32'(o_func_valid), 32'd1);
    tick();
    check("drop_valid", 32'(o_func_valid), 32'd0);
    check("drop_no_req", 32'(o_pi_req), 32'd0);
    i_honor = 1'b0;
    tick();
    check("idle_no_req", 32'(o_pi_req), 32'd0);
    tick();
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_cono_mtr = 1'b0;
    i_ebus_data = '0;
    i_cnt_cry = '0;
    i_interval_done = 1'b0;
    i_honor = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pi_req", 32'(o_pi_req), 32'd0);
    check("rst_pend", 32'(o_pend), 32'd0);
    check("rst_pia", 32'(o_pia), 32'd0);
    check("rst_valid", 32'(o_func_valid), 32'd0);
    i_rst_n = 1'b1;
    tick();

    // Basic service of PERF at level 3
    set_cono(1'b0, 3);
    tick();
    end_cono();
    check("pia_load", 32'(o_pia), 32'd3);
    i_cnt_cry = 4'b0100;
    tick();
    i_cnt_cry = '0;
    check("pend_perf", 32'(o_pend), 32'(5'b01000));
    check("no_req_same_edge", 32'(o_pi_req), 32'd0);
    tick();
    serve(3, 1'b0, 1);
    check("perf_cleared", 32'(o_pend), 32'd0);

    // All sources on the same edge, served in priority order
    i_cnt_cry = 4'b1111;
    i_interval_done = 1'b1;
    tick();
    i_cnt_cry = '0;
    check("pend_all", 32'(o_pend), 32'(5'b11111));
    tick();
    serve(3, 1'b0, 0);
    serve(3, 1'b0, 1);
    serve(3, 1'b0, 2);
    serve(3, 1'b0, 3);
    serve(3, 1'b1, 0);
    check("pend_all_done", 32'(o_pend), 32'd0);
    check("idle_after_all", 32'(o_pi_req), 32'd0);
    i_interval_done = 1'b0;

    // PIA=0 masks requests while events accumulate
    set_cono(1'b0, 0);
    tick();
    end_cono();
    i_cnt_cry = 4'b0001;
    tick();
    i_cnt_cry = '0;
    tick();
    tick();
    check("pia0_no_req", 32'(o_pi_req), 32'd0);
    check("pia0_pend", 32'(o_pend), 32'(5'b00010));
    set_cono(1'b0, 5);
    tick();
    end_cono();
    check("pia5_not_yet", 32'(o_pi_req), 32'd0);
    tick();
    serve(5, 1'b0, 3);

    // Clear-all on the same edge as a new EBOX carry
    i_cnt_cry = 4'b1000;
    tick();
    check("pend_time", 32'(o_pend), 32'(5'b10000));
    set_cono(1'b1, 5);
    i_cnt_cry = 4'b0010;
    tick();
    end_cono();
    i_cnt_cry = '0;
    check("clr_vs_set", 32'(o_pend), 32'(5'b00100));
    serve(5, 1'b0, 2);
    check("ebox_cleared", 32'(o_pend), 32'd0);

    // Repeat carries absorbed; PIA change while requesting
    set_cono(1'b0, 2);
    tick();
    end_cono();
    i_cnt_cry = 4'b0100;
    tick();
    tick();
    i_cnt_cry = '0;
    check("req_lvl2", 32'(o_pi_req), 32'(7'b0100000));
    set_cono(1'b0, 6);
    tick();
    end_cono();
    check("req_dropped", 32'(o_pi_req), 32'd0);
    check("pend_kept", 32'(o_pend), 32'(5'b01000));
    tick();
    serve(6, 1'b0, 1);
    check("repeat_absorbed", 32'(o_pend), 32'd0);

    // Asynchronous reset in the middle of XFER
    i_cnt_cry = 4'b1000;
    tick();
    i_cnt_cry = '0;
    tick();
    i_honor = 1'b1;
    tick();
    check("pre_rst_xfer", 32'(o_func_valid), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_pi_req", 32'(o_pi_req), 32'd0);
    check("arst_valid", 32'(o_func_valid), 32'd0);
    check("arst_vector", 32'(o_vector_req), 32'd0);
    check("arst_sel", 32'(o_incr_sel), 32'd0);
    check("arst_pia", 32'(o_pia), 32'd0);
    check("arst_pend", 32'(o_pend), 32'd0);
    i_honor = 1'b0;
    tick();
    i_rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_req", 32'(o_pi_req), 32'd0);
    check("post_rst_valid", 32'(o_func_valid), 32'd0);
    check("post_rst_pend", 32'(o_pend), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
